normalizer: RTL and testbench

Pipelined leading-one normalizer for the vector machine's floating-point datapath, and the inverse of the alignment shifter. It accepts a raw mantissa/exponent pair and shifts the mantissa left until its MSB is 1. The exponent is reduced by the same amount, with denormal clamping at exponent 0. It sits after the mantissa adder and before result packing, and uses a valid/ready handshake on both sides.

---
 rtl/normalizer_pkg.sv | 20 ++
 rtl/normalizer_lzc.sv | 32 +++
 rtl/normalizer.sv | 116 +++++++++++
 tb/tb_normalizer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/normalizer_pkg.sv
// =====================================================================
// normalizer_pkg : shared widths and result flag type for the normalizer
// rev 1.0
// =====================================================================
`default_nettype none

package normalizer_pkg;

   localparam int WORD_SIZE = 24;
   localparam int EXP_WIDTH = 8;
   localparam int LZ_WIDTH  = $clog2(WORD_SIZE + 1);

   typedef struct packed {
      logic zero;
      logic underflow;
   } norm_flags_t;

endpackage

`default_nettype wire

// File: rtl/normalizer_lzc.sv
// =====================================================================
// normalizer_lzc : combinational leading-zero counter, all-zero -> WIDTH
// rev 1.0
// =====================================================================
`default_nettype none

module normalizer_lzc
   import normalizer_pkg::*;
#(
   parameter int WIDTH = WORD_SIZE,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] count
);

   logic w_found;

   always_comb begin
      count   = CNT_W'(WIDTH);
      w_found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!w_found && data[i]) begin
            count   = CNT_W'(WIDTH - 1 - i);
            w_found = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/normalizer.sv
// =====================================================================
// normalizer : two-stage leading-one normalizer with denormal clamping
// rev 1.0
// =====================================================================
`default_nettype none

module normalizer
   import normalizer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_SIZE-1:0] in_mant,
   input  logic [EXP_WIDTH-1:0] in_exp,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_mant,
   output logic [EXP_WIDTH-1:0] out_exp,
   output logic                 out_zero,
   output logic                 out_underflow
);

   logic                 w_ready1;
   logic                 w_ready2;
   logic [LZ_WIDTH-1:0]  w_lz;

   logic                 r_v1;
   logic [WORD_SIZE-1:0] r_mant1;
   logic [EXP_WIDTH-1:0] r_exp1;
   logic [LZ_WIDTH-1:0]  r_lz1;

   logic                 r_v2;
   logic [WORD_SIZE-1:0] r_mant2;
   logic [EXP_WIDTH-1:0] r_exp2;
   norm_flags_t          r_flags2;

   logic                 w_mant_zero;
   logic                 w_lz_le_exp;
   logic [LZ_WIDTH-1:0]  w_shift;
   logic [WORD_SIZE-1:0] w_mant_n;
   logic [EXP_WIDTH-1:0] w_exp_n;
   norm_flags_t          w_flags_n;

   assign w_ready2 = !r_v2 || out_ready;
   assign w_ready1 = !r_v1 || w_ready2;
   assign in_ready = w_ready1;

   normalizer_lzc #(
      .WIDTH (WORD_SIZE),
      .CNT_W (LZ_WIDTH)
   ) u_lzc (
      .data  (in_mant),
      .count (w_lz)
   );

   // When lz exceeds exp, exp < WORD_SIZE so truncating it to the shift width is lossless
   assign w_mant_zero = (r_lz1 == LZ_WIDTH'(WORD_SIZE));
   assign w_lz_le_exp = (EXP_WIDTH'(r_lz1) <= r_exp1);
   assign w_shift     = w_lz_le_exp ? r_lz1 : LZ_WIDTH'(r_exp1);
   assign w_mant_n    = r_mant1 << w_shift;

   always_comb begin
      w_exp_n             = '0;
      w_flags_n.zero      = w_mant_zero;
      w_flags_n.underflow = 1'b0;
      if (!w_mant_zero) begin
         if (w_lz_le_exp) begin
            w_exp_n = r_exp1 - EXP_WIDTH'(r_lz1);
         end else begin
            w_flags_n.underflow = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1    <= 1'b0;
         r_mant1 <= '0;
         r_exp1  <= '0;
         r_lz1   <= '0;
      end else if (w_ready1) begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_mant1 <= in_mant;
            r_exp1  <= in_exp;
            r_lz1   <= w_lz;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v2     <= 1'b0;
         r_mant2  <= '0;
         r_exp2   <= '0;
         r_flags2 <= '0;
      end else if (w_ready2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_mant2  <= w_mant_n;
            r_exp2   <= w_exp_n;
            r_flags2 <= w_flags_n;
         end
      end
   end

   assign out_valid     = r_v2;
   assign out_mant      = r_mant2;
   assign out_exp       = r_exp2;
   assign out_zero      = r_flags2.zero;
   assign out_underflow = r_flags2.underflow;

endmodule

`default_nettype wire

// File: tb/tb_normalizer.sv
// =====================================================================
// tb_normalizer : vector table, corner sequences and random model check
// rev 1.0
// =====================================================================
`default_nettype none

module tb_normalizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_mant;
   logic [7:0]  in_exp;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_mant;
   logic [7:0]  out_exp;
   logic        out_zero;
   logic        out_underflow;

   normalizer dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_mant       (in_mant),
      .in_exp        (in_exp),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_mant      (out_mant),
      .out_exp       (out_exp),
      .out_zero      (out_zero),
      .out_underflow (out_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] m;
      logic [7:0]  e;
      logic [23:0] xm;
      logic [7:0]  xe;
      logic        xz;
      logic        xu;
   } vec_t;

   vec_t        vecs[10];
   logic [33:0] q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_out = 0;
   logic        prev_hold = 1'b0;
   logic [33:0] prev_out;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Walk the mantissa up one bit at a time while exponent allows it
   function automatic logic [33:0] ref_norm(input logic [23:0] m, input logic [7:0] e);
      logic [23:0] mm;
      int          ee;
      mm = m;
      ee = e;
      if (m == 24'h0) return {24'h0, 8'h0, 1'b1, 1'b0};
      while (!mm[23] && ee > 0) begin
         mm = mm << 1;
         ee--;
      end
      return {mm, 8'(ee), 1'b0, !mm[23]};
   endfunction

   function automatic logic [33:0] outs();
      return {out_mant, out_exp, out_zero, out_underflow};
   endfunction

   // One clock: starts and ends on a falling edge
   task automatic step(input logic iv, input logic [23:0] m, input logic [7:0] e,
                       input logic ordy, output logic acc);
      in_valid  = iv;
      in_mant   = m;
      in_exp    = e;
      out_ready = ordy;
      #1;
      if (prev_hold) check("hold_stable", {out_valid, outs()}, {1'b1, prev_out});
      if (out_valid && out_ready) begin
         n_out++;
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_output: got %h, expected no output", outs());
         end else begin
            check("stream_data", outs(), q.pop_front());
         end
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = outs();
      acc = iv && in_ready;
      if (acc) q.push_back(ref_norm(m, e));
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic acc;
      int   accepted;
      int   cycles;
      int   out_base;
      logic [23:0] rm;
      logic [7:0]  re;

      vecs[0] = '{24'h000020,  8'd20, 24'h800000,   8'd2, 1'b0, 1'b0};
      vecs[1] = '{24'h000002,   8'd4, 24'h000020,   8'd0, 1'b0, 1'b1};
      vecs[2] = '{24'h000001,  8'd23, 24'h800000,   8'd0, 1'b0, 1'b0};
      vecs[3] = '{24'h000000,  8'd57, 24'h000000,   8'd0, 1'b1, 1'b0};
      vecs[4] = '{24'h800001, 8'd100, 24'h800001, 8'd100, 1'b0, 1'b0};
      vecs[5] = '{24'h000001,   8'd0, 24'h000001,   8'd0, 1'b0, 1'b1};
      vecs[6] = '{24'h000000,   8'd0, 24'h000000,   8'd0, 1'b1, 1'b0};
      vecs[7] = '{24'h400000,   8'd1, 24'h800000,   8'd0, 1'b0, 1'b0};
      vecs[8] = '{24'h000001, 8'd255, 24'h800000, 8'd232, 1'b0, 1'b0};
      vecs[9] = '{24'h0F0000,   8'd3, 24'h780000,   8'd0, 1'b0, 1'b1};

      rst = 1'b1;
      in_valid = 1'b0;
      in_mant = '0;
      in_exp = '0;
      out_ready = 1'b0;
      #1;
      check("reset_outputs", {out_valid, outs()}, 35'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_reset", in_ready, 1'b1);
      @(negedge clk);

      // Directed vectors with exact two-cycle latency
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_mant = vecs[i].m;
         in_exp = vecs[i].e;
         out_ready = 1'b1;
         #1;
         check("vec_in_ready", in_ready, 1'b1);
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         check("vec_latency", out_valid, 1'b0);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d", i), {out_valid, outs()},
               {1'b1, vecs[i].xm, vecs[i].xe, vecs[i].xz, vecs[i].xu});
         @(posedge clk);
         @(negedge clk);
      end

      // Backpressure: five inputs, consumer stalled for four cycles
      accepted = 0;
      out_base = n_out;
      for (int c = 0; c < 4; c++) begin
         step(1'b1, 24'h000100 << accepted, 8'(10 + accepted), 1'b0, acc);
         if (acc) accepted++;
      end
      check("bp_accepts", accepted, 2);
      in_valid = 1'b1;
      #1;
      check("bp_in_ready_low", in_ready, 1'b0);
      @(negedge clk);
      cycles = 0;
      while ((accepted < 5 || q.size() != 0) && cycles < 30) begin
         step(accepted < 5, 24'h000100 << accepted, 8'(10 + accepted), 1'b1, acc);
         if (acc) accepted++;
         cycles++;
      end
      check("bp_emitted", n_out - out_base, 5);
      check("bp_drained", q.size(), 0);

      // Reset with both stages full
      step(1'b1, 24'h000003, 8'd40, 1'b0, acc);
      step(1'b1, 24'h000005, 8'd41, 1'b0, acc);
      in_valid = 1'b0;
      #1;
      check("full_before_rst", {out_valid, in_ready}, 2'b10);
      rst = 1'b1;
      #1;
      check("rst_mid_outputs", {out_valid, outs()}, 35'h0);
      q.delete();
      prev_hold = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mid_ready", in_ready, 1'b1);
      for (int c = 0; c < 4; c++) step(1'b0, 24'h0, 8'h0, 1'b1, acc);
      check("rst_no_stale", out_valid, 1'b0);

      // Random stream with random backpressure
      accepted = 0;
      cycles = 0;
      while (accepted < 10000 && cycles < 60000) begin
         rm = 24'($urandom) >> $urandom_range(0, 24);
         re = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
         step($urandom_range(0, 3) != 0, rm, re, $urandom_range(0, 3) != 0, acc);
         if (acc) accepted++;
         cycles++;
      end
      cycles = 0;
      while (q.size() != 0 && cycles < 50) begin
         step(1'b0, 24'h0, 8'h0, 1'b1, acc);
         cycles++;
      end
      check("rand_accepted", accepted, 10000);
      check("rand_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
